fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the program memory and feeds the decoder. It owns the 8-bit program counter and drives it as the program-memory address. It latches the returned 17-bit instruction word into an instruction register with a valid flag and the matching PC. It handles decode stalls, execute-stage redirects (jumps and taken branches), and a halt/resume control.

Parameters:
PC_WIDTH, 8, program counter and program-memory address width
INSTR_WIDTH, 17, instruction width (5-bit opcode + four 3-bit fields)
RESET_PC, 0, PC value loaded on reset
COUNT_WIDTH, 16, width of the fetched-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
stall  input  1  decoder cannot accept; hold PC and IR
redirect_valid  input  1  execute stage requests PC change this cycle
redirect_target  input  PC_WIDTH  new PC when redirect_valid=1
halt_req  input  1  request to stop fetching
resume  input  1  leave HALTED state
pm_address  output  PC_WIDTH  address to program memory (equals pc)
pm_data  input  INSTR_WIDTH  combinational instruction word from program memory
ir  output  INSTR_WIDTH  registered instruction to decoder
ir_valid  output  1  ir holds a real instruction
ir_pc  output  PC_WIDTH  address ir was fetched from
halted  output  1  state==HALTED
fetch_count  output  COUNT_WIDTH  number of instructions accepted into ir

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, ir=NOP_WORD (17'h00000), ir_valid=0, ir_pc=0, fetch_count=0, state=FETCH. All outputs hold these values while reset is low.
- pm_address = pc, combinational. Memory is asynchronous-read, so pm_data is valid in the same cycle. Fetch latency is one clock from pc to ir.
- States: FETCH, HALTED. halted=1 only in HALTED.
- Per rising edge, evaluated in priority order:
  1. redirect_valid=1 (any state):
     - pc<=redirect_target; ir<=NOP_WORD; ir_valid<=0. The wrong-path word is squashed.
     - State is unchanged. A redirect in HALTED updates pc and stays HALTED.
     - redirect overrides stall and halt_req in the same cycle; halt_req is dropped, not deferred.
  2. state=HALTED:
     - resume=1: state<=FETCH; no fetch this edge.
     - otherwise hold everything. ir_valid stays 0.
  3. state=FETCH, halt_req=1: state<=HALTED; ir<=NOP_WORD; ir_valid<=0; pc held. The word at pc is refetched after resume.
  4. state=FETCH, stall=1: pc, ir, ir_valid, ir_pc all held.
  5. state=FETCH, normal: ir<=pm_data; ir_pc<=pc; ir_valid<=1; pc<=pc+1; fetch_count<=fetch_count+1.
- pc+1 wraps modulo 2^PC_WIDTH (255 -> 0). fetch_count wraps silently at all-ones.
- stall has no effect in HALTED.
- resume and halt_req both high in FETCH: halt wins.
- An X or unmapped pm_data word is passed through unchanged; decoding it is the decoder's job.

Decomposition:
- Shared package isa_pkg, used by fetch, decode and program memory:
  - opcode constants NOP..LSR (5'b00000..5'b10101: NOP, SUB, JML, JMP, AIU, ST, AND, JMR, LSL, ADI, XOR, BZ, MOV, LD, SLT, ADD, OUT, NOT, IN, BNZ, ORI, LSR)
  - field widths OPC_W=5, REG_W=3, PC_W=8, INSTR_W=17
  - NOP_WORD=17'h00000
  - state encoding FETCH=1'b0, HALTED=1'b1
- Single module; no sub-module is warranted.

Test Plan:
- Reset release with pm_data model: addr0=17'h12200 (IN R1), addr1=17'h08444 (LSL R2,R1,4) -> after edge 1: ir=12200, ir_pc=0, ir_valid=1, pm_address=1. After edge 2: ir=08444, ir_pc=1, fetch_count=2.
- stall=1 for 3 cycles at pc=3 -> pc, ir, ir_pc, fetch_count unchanged for 3 edges. After stall drops, the next edge captures addr3 word.
- redirect_valid=1, target=8'h00, together with stall=1 at pc=6 -> next edge: pc=0, ir_valid=0, ir=00000. The following edge: ir=12200, ir_pc=0.
- pc=8'hFF, no stall -> after edge ir_pc=FF, pc=00, ir_valid=1 (wrap).
- halt_req at pc=4 -> halted=1, ir_valid=0, pc stays 4 for 5 cycles. Then resume -> FETCH after 1 edge, and the next edge captures addr4 with ir_pc=4.
- Assert reset low mid-run with pc=5 and ir_valid=1, asynchronously between edges -> outputs immediately pc=0, ir=00000, ir_valid=0, fetch_count=0, halted=0.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for fetch, decode and program memory.
// Opcode map, field widths, the NOP word and the fetch state encoding.
package isa_pkg;

    localparam int OPC_W   = 5;
    localparam int REG_W   = 3;
    localparam int PC_W    = 8;
    localparam int INSTR_W = 17;

    localparam logic [INSTR_W-1:0] NOP_WORD = 17'h00000;

    typedef enum logic [OPC_W-1:0] {
        NOP = 5'b00000,
        SUB = 5'b00001,
        JML = 5'b00010,
        JMP = 5'b00011,
        AIU = 5'b00100,
        ST  = 5'b00101,
        AND = 5'b00110,
        JMR = 5'b00111,
        LSL = 5'b01000,
        ADI = 5'b01001,
        XOR = 5'b01010,
        BZ  = 5'b01011,
        MOV = 5'b01100,
        LD  = 5'b01101,
        SLT = 5'b01110,
        ADD = 5'b01111,
        OUT = 5'b10000,
        NOT = 5'b10001,
        IN  = 5'b10010,
        BNZ = 5'b10011,
        ORI = 5'b10100,
        LSR = 5'b10101
    } opcode_t;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, latches program-memory words into
// the IR, and handles stalls, execute redirects and halt/resume.
module fetch_unit
    import isa_pkg::*;
#(
    parameter int          PC_WIDTH    = 8,
    parameter int          INSTR_WIDTH = 17,
    parameter int unsigned RESET_PC    = 0,
    parameter int          COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_target,
    input  logic                   halt_req,
    input  logic                   resume,
    output logic [PC_WIDTH-1:0]    pm_address,
    input  logic [INSTR_WIDTH-1:0] pm_data,
    output logic [INSTR_WIDTH-1:0] ir,
    output logic                   ir_valid,
    output logic [PC_WIDTH-1:0]    ir_pc,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] fetch_count
);

    localparam logic [INSTR_WIDTH-1:0] IR_NOP = INSTR_WIDTH'(NOP_WORD);
    localparam logic [PC_WIDTH-1:0]    PC_RST = PC_WIDTH'(RESET_PC);

    fetch_state_t state_q, state_d;

    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   valid_q, valid_d;
    logic [PC_WIDTH-1:0]    ir_pc_q, ir_pc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= PC_RST;
            ir_q    <= IR_NOP;
            valid_q <= 1'b0;
            ir_pc_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            ir_pc_q <= ir_pc_d;
            count_q <= count_d;
        end
    end

    // Priority: redirect, then halted handling, then halt, stall, fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        ir_pc_d = ir_pc_q;
        count_d = count_q;

        if (redirect_valid) begin
            pc_d    = redirect_target;
            ir_d    = IR_NOP;
            valid_d = 1'b0;
        end else if (state_q == HALTED) begin
            if (resume) begin
                state_d = FETCH;
            end
        end else if (halt_req) begin
            state_d = HALTED;
            ir_d    = IR_NOP;
            valid_d = 1'b0;
        end else if (!stall) begin
            ir_d    = pm_data;
            ir_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_WIDTH'(1);
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    assign pm_address  = pc_q;
    assign ir          = ir_q;
    assign ir_valid    = valid_q;
    assign ir_pc       = ir_pc_q;
    assign fetch_count = count_q;
    assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with an async-read
// program memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic        halt_req;
    logic        resume;
    logic [7:0]  pm_address;
    logic [16:0] pm_data;
    logic [16:0] ir;
    logic        ir_valid;
    logic [7:0]  ir_pc;
    logic        halted;
    logic [15:0] fetch_count;

    logic [16:0] mem [256];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign pm_data = mem[pm_address];

    fetch_unit dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .halt_req(halt_req),
        .resume(resume),
        .pm_address(pm_address),
        .pm_data(pm_data),
        .ir(ir),
        .ir_valid(ir_valid),
        .ir_pc(ir_pc),
        .halted(halted),
        .fetch_count(fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 8'h00;
        halt_req = 1'b0;
        resume = 1'b0;
        step();
        step();
        checks++; if (pm_address !== 8'h00) begin failures++; $display("FAIL rst_pc got=%h exp=00", pm_address); end
        checks++; if (ir !== 17'h00000) begin failures++; $display("FAIL rst_ir got=%h exp=00000", ir); end
        checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ir_valid); end
        checks++; if (ir_pc !== 8'h00) begin failures++; $display("FAIL rst_ir_pc got=%h exp=00", ir_pc); end
        checks++; if (fetch_count !== 16'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", fetch_count); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b exp=0", halted); end
        reset = 1'b1;
    endtask

    task automatic test_fetch();
        step();
        checks++; if (ir !== 17'h12200) begin failures++; $display("FAIL f1_ir got=%h exp=12200", ir); end
        checks++; if (ir_pc !== 8'h00) begin failures++; $display("FAIL f1_ir_pc got=%h exp=00", ir_pc); end
        checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL f1_valid got=%b exp=1", ir_valid); end
        checks++; if (pm_address !== 8'h01) begin failures++; $display("FAIL f1_pc got=%h exp=01", pm_address); end
        step();
        checks++; if (ir !== 17'h08444) begin failures++; $display("FAIL f2_ir got=%h exp=08444", ir); end
        checks++; if (ir_pc !== 8'h01) begin failures++; $display("FAIL f2_ir_pc got=%h exp=01", ir_pc); end
        checks++; if (fetch_count !== 16'd2) begin failures++; $display("FAIL f2_count got=%0d exp=2", fetch_count); end
        step();
        checks++; if (ir !== 17'h102FD) begin failures++; $display("FAIL f3_ir got=%h exp=102fd", ir); end
        checks++; if (pm_address !== 8'h03) begin failures++; $display("FAIL f3_pc got=%h exp=03", pm_address); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pm_address !== 8'h03) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=03", i, pm_address); end
            checks++; if (ir !== 17'h102FD) begin failures++; $display("FAIL stall_ir[%0d] got=%h exp=102fd", i, ir); end
            checks++; if (ir_pc !== 8'h02) begin failures++; $display("FAIL stall_ir_pc[%0d] got=%h exp=02", i, ir_pc); end
            checks++; if (fetch_count !== 16'd3) begin failures++; $display("FAIL stall_count[%0d] got=%0d exp=3", i, fetch_count); end
        end
        stall = 1'b0;
        step();
        checks++; if (ir !== 17'h103FC) begin failures++; $display("FAIL unstall_ir got=%h exp=103fc", ir); end
        checks++; if (ir_pc !== 8'h03) begin failures++; $display("FAIL unstall_ir_pc got=%h exp=03", ir_pc); end
        checks++; if (fetch_count !== 16'd4) begin failures++; $display("FAIL unstall_count got=%0d exp=4", fetch_count); end
    endtask

    task automatic test_halt();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_halted got=%b exp=1", halted); end
        checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL halt_valid got=%b exp=0", ir_valid); end
        checks++; if (ir !== 17'h00000) begin failures++; $display("FAIL halt_ir got=%h exp=00000", ir); end
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (pm_address !== 8'h04) begin failures++; $display("FAIL halt_pc[%0d] got=%h exp=04", i, pm_address); end
            checks++; if (halted !== 1'b1 || ir_valid !== 1'b0) begin failures++; $display("FAIL halt_hold[%0d] got=%b%b exp=10", i, halted, ir_valid); end
        end
        stall = 1'b0;
        resume = 1'b1;
        step();
        resume = 1'b0;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL resume_halted got=%b exp=0", halted); end
        checks++; if (ir_valid !== 1'b0 || pm_address !== 8'h04) begin failures++; $display("FAIL resume_nofetch got=%b/%h exp=0/04", ir_valid, pm_address); end
        step();
        checks++; if (ir !== 17'h104FB) begin failures++; $display("FAIL refetch_ir got=%h exp=104fb", ir); end
        checks++; if (ir_pc !== 8'h04) begin failures++; $display("FAIL refetch_ir_pc got=%h exp=04", ir_pc); end
        checks++; if (fetch_count !== 16'd5) begin failures++; $display("FAIL refetch_count got=%0d exp=5", fetch_count); end
    endtask

    task automatic test_redirect();
        step();
        checks++; if (pm_address !== 8'h06) begin failures++; $display("FAIL pre_redir_pc got=%h exp=06", pm_address); end
        redirect_valid = 1'b1;
        redirect_target = 8'h00;
        stall = 1'b1;
        halt_req = 1'b1;
        step();
        redirect_valid = 1'b0;
        stall = 1'b0;
        halt_req = 1'b0;
        checks++; if (pm_address !== 8'h00) begin failures++; $display("FAIL redir_pc got=%h exp=00", pm_address); end
        checks++; if (ir_valid !== 1'b0 || ir !== 17'h00000) begin failures++; $display("FAIL redir_squash got=%b/%h exp=0/00000", ir_valid, ir); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL redir_halt_drop got=%b exp=0", halted); end
        checks++; if (fetch_count !== 16'd6) begin failures++; $display("FAIL redir_count got=%0d exp=6", fetch_count); end
        step();
        checks++; if (ir !== 17'h12200 || ir_pc !== 8'h00) begin failures++; $display("FAIL post_redir got=%h/%h exp=12200/00", ir, ir_pc); end
        checks++; if (fetch_count !== 16'd7) begin failures++; $display("FAIL post_redir_count got=%0d exp=7", fetch_count); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_target = 8'hFF;
        step();
        redirect_valid = 1'b0;
        checks++; if (pm_address !== 8'hFF) begin failures++; $display("FAIL wrap_setup got=%h exp=ff", pm_address); end
        step();
        checks++; if (ir_pc !== 8'hFF) begin failures++; $display("FAIL wrap_ir_pc got=%h exp=ff", ir_pc); end
        checks++; if (pm_address !== 8'h00) begin failures++; $display("FAIL wrap_pc got=%h exp=00", pm_address); end
        checks++; if (ir_valid !== 1'b1 || ir !== 17'h1FF00) begin failures++; $display("FAIL wrap_ir got=%b/%h exp=1/1ff00", ir_valid, ir); end
        checks++; if (fetch_count !== 16'd8) begin failures++; $display("FAIL wrap_count got=%0d exp=8", fetch_count); end
    endtask

    task automatic test_halt_redirect();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 8'h10;
        resume = 1'b1;
        step();
        redirect_valid = 1'b0;
        checks++; if (pm_address !== 8'h10 || halted !== 1'b1) begin failures++; $display("FAIL halt_redir got=%h/%b exp=10/1", pm_address, halted); end
        step();
        resume = 1'b0;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_redir_resume got=%b exp=0", halted); end
        step();
        checks++; if (ir !== 17'h110EF || ir_pc !== 8'h10) begin failures++; $display("FAIL halt_redir_fetch got=%h/%h exp=110ef/10", ir, ir_pc); end
        checks++; if (fetch_count !== 16'd9) begin failures++; $display("FAIL halt_redir_count got=%0d exp=9", fetch_count); end
    endtask

    task automatic test_halt_vs_resume();
        halt_req = 1'b1;
        resume = 1'b1;
        step();
        halt_req = 1'b0;
        checks++; if (halted !== 1'b1 || pm_address !== 8'h11) begin failures++; $display("FAIL halt_wins got=%b/%h exp=1/11", halted, pm_address); end
        step();
        resume = 1'b0;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL hvr_resume got=%b exp=0", halted); end
        step();
        checks++; if (ir_pc !== 8'h11 || ir_valid !== 1'b1) begin failures++; $display("FAIL hvr_fetch got=%h/%b exp=11/1", ir_pc, ir_valid); end
        checks++; if (fetch_count !== 16'd10) begin failures++; $display("FAIL hvr_count got=%0d exp=10", fetch_count); end
    endtask

    task automatic test_async_reset();
        #3;
        reset = 1'b0;
        #1;
        checks++; if (pm_address !== 8'h00) begin failures++; $display("FAIL areset_pc got=%h exp=00", pm_address); end
        checks++; if (ir !== 17'h00000 || ir_valid !== 1'b0) begin failures++; $display("FAIL areset_ir got=%h/%b exp=00000/0", ir, ir_valid); end
        checks++; if (fetch_count !== 16'd0 || halted !== 1'b0) begin failures++; $display("FAIL areset_cnt got=%0d/%b exp=0/0", fetch_count, halted); end
        step();
        checks++; if (pm_address !== 8'h00 || ir_valid !== 1'b0) begin failures++; $display("FAIL areset_hold got=%h/%b exp=00/0", pm_address, ir_valid); end
        reset = 1'b1;
        step();
        checks++; if (ir !== 17'h12200 || fetch_count !== 16'd1) begin failures++; $display("FAIL areset_restart got=%h/%0d exp=12200/1", ir, fetch_count); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = {1'b1, 8'(i), ~8'(i)};
        end
        mem[0] = 17'h12200;
        mem[1] = 17'h08444;
        test_reset();
        test_fetch();
        test_stall();
        test_halt();
        test_redirect();
        test_wrap();
        test_halt_redirect();
        test_halt_vs_resume();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
